mem_arbiter: RTL and testbench

//   Shares one mem1port single-port RAM between the instruction-fetch read port and the data port.
//   The data port can issue a read and a write in the same cycle.

---
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundles the instruction-fetch port, the data read/write ports and the mem1port side of the arbiter.
// The slave modport is the arbiter's view; the master modport is the cores/RAM view.
interface mem_arbiter_if;
  logic        i_rready;
  logic [29:0] i_raddr;
  logic        i_rack;
  logic        i_rresp;
  logic [31:0] i_rdata;

  logic        d_rready;
  logic [29:0] d_raddr;
  logic        d_rack;
  logic        d_rresp;
  logic [31:0] d_rdata;

  logic        d_wready;
  logic [29:0] d_waddr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_wack;

  logic        mem_ready;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rresp;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_rready, i_raddr, d_rready, d_raddr,
    input  d_wready, d_waddr, d_wdata, d_wstrb,
    input  mem_rresp, mem_rdata,
    output i_rack, i_rresp, i_rdata, d_rack, d_rresp, d_rdata, d_wack,
    output mem_ready, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output i_rready, i_raddr, d_rready, d_raddr,
    output d_wready, d_waddr, d_wdata, d_wstrb,
    output mem_rresp, mem_rdata,
    input  i_rack, i_rresp, i_rdata, d_rack, d_rresp, d_rdata, d_wack,
    input  mem_ready, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and the data port, with a one-entry
// posted write buffer and a starvation bound on instruction fetches.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          resetb,
  mem_arbiter_if.slave  bus
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_I, GNT_D} grant_e;

  logic          r_wb_valid;
  logic [29:0]   r_wb_addr;
  logic [31:0]   r_wb_data;
  logic [3:0]    r_wb_strb;
  logic          r_owner;
  logic [CW-1:0] r_starve_cnt;

  grant_e        w_grant;
  logic          w_d_hit;
  logic          w_wack;
  logic          w_capture;
  logic [29:0]   w_mem_addr;
  logic [31:0]   w_mem_wdata;
  logic [3:0]    w_mem_wstrb;

  assign w_d_hit = r_wb_valid && (bus.d_raddr == r_wb_addr);

  // Nothing is granted while reset is held, so every ack and mem_* output stays low.
  always_comb begin
    w_grant = GNT_NONE;
    if (!resetb) begin
      w_grant = GNT_NONE;
    end else if (r_wb_valid && (bus.d_wready || (!bus.i_rready && !bus.d_rready) ||
                                (bus.d_rready && w_d_hit))) begin
      w_grant = GNT_WB;
    end else if (bus.i_rready && r_starve_cnt == STARVE_LIM) begin
      w_grant = GNT_I;
    end else if (bus.d_rready && !w_d_hit) begin
      w_grant = GNT_D;
    end else if (bus.i_rready) begin
      w_grant = GNT_I;
    end else if (r_wb_valid) begin
      w_grant = GNT_WB;
    end
  end

  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_wstrb = '0;
    case (w_grant)
      GNT_WB: begin
        w_mem_addr  = r_wb_addr;
        w_mem_wdata = r_wb_data;
        w_mem_wstrb = r_wb_strb;
      end
      GNT_I:   w_mem_addr = bus.i_raddr;
      GNT_D:   w_mem_addr = bus.d_raddr;
      default: w_mem_addr = '0;
    endcase
  end

  assign w_wack    = resetb && bus.d_wready && (!r_wb_valid || w_grant == GNT_WB);
  assign w_capture = w_wack && (bus.d_wstrb != 4'h0);

  assign bus.mem_ready = (w_grant != GNT_NONE);
  assign bus.mem_we    = (w_grant == GNT_WB);
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.mem_wstrb = w_mem_wstrb;
  assign bus.i_rack    = (w_grant == GNT_I);
  assign bus.d_rack    = (w_grant == GNT_D);
  assign bus.d_wack    = w_wack;
  assign bus.i_rresp   = resetb && bus.mem_rresp && !r_owner;
  assign bus.d_rresp   = resetb && bus.mem_rresp && r_owner;
  assign bus.i_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

  // A drain and a new capture can happen in the same cycle; the capture wins.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_wb_strb  <= '0;
    end else if (w_capture) begin
      r_wb_valid <= 1'b1;
      r_wb_addr  <= bus.d_waddr;
      r_wb_data  <= bus.d_wdata;
      r_wb_strb  <= bus.d_wstrb;
    end else if (w_grant == GNT_WB) begin
      r_wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_owner <= 1'b0;
    end else if (w_grant == GNT_I || w_grant == GNT_D) begin
      r_owner <= (w_grant == GNT_D);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_starve_cnt <= '0;
    end else if (!bus.i_rready || w_grant == GNT_I) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != STARVE_LIM) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM (1-cycle read latency).
// Expected values are hand-computed from the initial RAM image ram[a] = 0x1000_0000 + a.
module tb_mem_arbiter;
  logic clk;
  logic resetb;
  int   n_checks;
  int   n_fail;

  logic [31:0] ram [0:255];
  bit          ram_init;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model; its response register resets together with the arbiter.
  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      bus.mem_rresp <= 1'b0;
      bus.mem_rdata <= '0;
      if (!ram_init) begin
        for (int a = 0; a < 256; a++) ram[a] <= 32'h1000_0000 + 32'(a);
        ram_init <= 1'b1;
      end
    end else begin
      bus.mem_rresp <= bus.mem_ready && !bus.mem_we;
      if (bus.mem_ready && !bus.mem_we) bus.mem_rdata <= ram[bus.mem_addr[7:0]];
      if (bus.mem_ready && bus.mem_we)
        for (int b = 0; b < 4; b++)
          if (bus.mem_wstrb[b]) ram[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.i_rready = 1'b0; bus.i_raddr = '0;
    bus.d_rready = 1'b0; bus.d_raddr = '0;
    bus.d_wready = 1'b0; bus.d_waddr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
  endtask

  task automatic set_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.d_wready = 1'b1; bus.d_waddr = a; bus.d_wdata = d; bus.d_wstrb = s;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetb   = 1'b0;
    idle_inputs();

    // Requests presented during reset must not be granted.
    bus.i_rready = 1'b1; bus.i_raddr = 30'h10;
    bus.d_rready = 1'b1; bus.d_raddr = 30'h11;
    set_write(30'h12, 32'h1234_5678, 4'hF);
    repeat (3) tick();
    mid();
    chk1("rst_i_rack", bus.i_rack, 1'b0);
    chk1("rst_d_rack", bus.d_rack, 1'b0);
    chk1("rst_d_wack", bus.d_wack, 1'b0);
    chk1("rst_mem_ready", bus.mem_ready, 1'b0);
    chk1("rst_i_rresp", bus.i_rresp, 1'b0);
    tick();
    idle_inputs();
    resetb = 1'b1;
    mid();
    chk1("post_rst_mem_ready", bus.mem_ready, 1'b0);
    tick();

    // Idle instruction fetch
    bus.i_rready = 1'b1; bus.i_raddr = 30'h10;
    mid();
    chk1("idle_i_rack", bus.i_rack, 1'b1);
    chk32("idle_mem_addr", 32'(bus.mem_addr), 32'h10);
    chk1("idle_mem_we", bus.mem_we, 1'b0);
    tick();
    bus.i_rready = 1'b0;
    mid();
    chk1("idle_i_rresp", bus.i_rresp, 1'b1);
    chk1("idle_d_rresp", bus.d_rresp, 1'b0);
    chk32("idle_i_rdata", bus.i_rdata, 32'h1000_0010);
    tick();

    // Contention: D,D,D,D,I repeating
    bus.i_rready = 1'b1; bus.i_raddr = 30'h11;
    bus.d_rready = 1'b1; bus.d_raddr = 30'h12;
    for (int k = 0; k < 10; k++) begin
      mid();
      chk1("cont_i_rack", bus.i_rack, (k % 5) == 4);
      chk1("cont_d_rack", bus.d_rack, (k % 5) != 4);
      if (k > 0) begin
        chk1("cont_i_rresp", bus.i_rresp, ((k - 1) % 5) == 4);
        chk1("cont_d_rresp", bus.d_rresp, ((k - 1) % 5) != 4);
        chk32("cont_rdata", bus.d_rdata, (((k - 1) % 5) == 4) ? 32'h1000_0011 : 32'h1000_0012);
      end
      tick();
    end
    idle_inputs();
    mid();
    chk1("cont_last_i_rresp", bus.i_rresp, 1'b1);
    chk32("cont_last_i_rdata", bus.i_rdata, 32'h1000_0011);
    tick();

    // Posted write, drained the next cycle, then read back
    set_write(30'h20, 32'hA5A5_A5A5, 4'hF);
    mid();
    chk1("pw_d_wack", bus.d_wack, 1'b1);
    chk1("pw_c0_mem_ready", bus.mem_ready, 1'b0);
    tick();
    idle_inputs();
    mid();
    chk1("pw_c1_mem_we", bus.mem_we, 1'b1);
    chk32("pw_c1_mem_addr", 32'(bus.mem_addr), 32'h20);
    chk32("pw_c1_mem_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    chk32("pw_c1_mem_wstrb", 32'(bus.mem_wstrb), 32'hF);
    tick();
    bus.d_rready = 1'b1; bus.d_raddr = 30'h20;
    mid();
    chk1("pw_rd_d_rack", bus.d_rack, 1'b1);
    tick();
    idle_inputs();
    mid();
    chk1("pw_rd_d_rresp", bus.d_rresp, 1'b1);
    chk32("pw_rd_d_rdata", bus.d_rdata, 32'hA5A5_A5A5);
    tick();

    // RAW hazard: read of the buffered address waits for the drain
    set_write(30'h30, 32'hDEAD_BEEF, 4'h3);
    mid();
    chk1("raw_d_wack", bus.d_wack, 1'b1);
    tick();
    idle_inputs();
    bus.d_rready = 1'b1; bus.d_raddr = 30'h30;
    mid();
    chk1("raw_wb_first_we", bus.mem_we, 1'b1);
    chk1("raw_wb_first_d_rack", bus.d_rack, 1'b0);
    tick();
    mid();
    chk1("raw_then_d_rack", bus.d_rack, 1'b1);
    chk32("raw_then_addr", 32'(bus.mem_addr), 32'h30);
    tick();
    idle_inputs();
    mid();
    chk1("raw_d_rresp", bus.d_rresp, 1'b1);
    chk32("raw_merged", bus.d_rdata, 32'h1000_BEEF);
    tick();

    // Back-to-back writes plus a read to another address
    set_write(30'h40, 32'h1111_1111, 4'hF);
    tick();
    set_write(30'h41, 32'h2222_2222, 4'hF);
    bus.d_rready = 1'b1; bus.d_raddr = 30'h42;
    mid();
    chk1("b2b_drain_we", bus.mem_we, 1'b1);
    chk32("b2b_drain_addr", 32'(bus.mem_addr), 32'h40);
    chk1("b2b_capture_wack", bus.d_wack, 1'b1);
    chk1("b2b_d_rack_wait", bus.d_rack, 1'b0);
    tick();
    bus.d_wready = 1'b0;
    mid();
    chk1("b2b_d_rack", bus.d_rack, 1'b1);
    chk32("b2b_rd_addr", 32'(bus.mem_addr), 32'h42);
    tick();
    idle_inputs();
    mid();
    chk32("b2b_d_rdata", bus.d_rdata, 32'h1000_0042);
    chk1("b2b_second_drain_we", bus.mem_we, 1'b1);
    chk32("b2b_second_drain_addr", 32'(bus.mem_addr), 32'h41);
    tick();
    bus.d_rready = 1'b1; bus.d_raddr = 30'h40;
    tick();
    bus.d_raddr = 30'h41;
    mid();
    chk32("b2b_rd40", bus.d_rdata, 32'h1111_1111);
    tick();
    idle_inputs();
    mid();
    chk32("b2b_rd41", bus.d_rdata, 32'h2222_2222);
    tick();

    // Zero-strobe write is acked and dropped
    set_write(30'h50, 32'hFFFF_FFFF, 4'h0);
    mid();
    chk1("zs_d_wack", bus.d_wack, 1'b1);
    tick();
    idle_inputs();
    mid();
    chk1("zs_no_drain", bus.mem_ready, 1'b0);
    tick();

    // Reset mid-operation with a buffered write and starve count nonzero
    set_write(30'h60, 32'hCAFE_F00D, 4'hF);
    tick();
    idle_inputs();
    bus.i_rready = 1'b1; bus.i_raddr = 30'h11;
    bus.d_rready = 1'b1; bus.d_raddr = 30'h61;
    tick();
    resetb = 1'b0;
    mid();
    chk1("mrst_i_rack", bus.i_rack, 1'b0);
    chk1("mrst_d_rack", bus.d_rack, 1'b0);
    chk1("mrst_mem_ready", bus.mem_ready, 1'b0);
    chk1("mrst_d_rresp", bus.d_rresp, 1'b0);
    tick();
    idle_inputs();
    resetb = 1'b1;
    mid();
    chk1("mrst_wb_discarded", bus.mem_ready, 1'b0);
    tick();
    bus.i_rready = 1'b1; bus.i_raddr = 30'h11;
    bus.d_rready = 1'b1; bus.d_raddr = 30'h12;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk1("mrst_starve_i_rack", bus.i_rack, k == 4);
      tick();
    end
    idle_inputs();
    bus.d_rready = 1'b1; bus.d_raddr = 30'h60;
    tick();
    idle_inputs();
    mid();
    chk32("mrst_mem_unchanged", bus.d_rdata, 32'h1000_0060);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
